// File: rtl/pc_seq.sv
// Program-counter sequencer: owns the PC and the IDLE/RUN/HALT run state, applies LUT branch offsets.
// PC, state and counters update one clock after their inputs; Stall freezes the PC but never the cycle count.
module pc_seq #(
    parameter int PC_W  = 8,
    parameter int PTR_W = 5,
    parameter int CNT_W = 16
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    Start,
    input  logic                    Stall,
    input  logic                    Branch_en,
    input  logic                    Halt_in,
    input  logic [PTR_W-1:0]        Target_in,
    output logic [PTR_W-1:0]        Lut_ptr,
    input  logic signed [7:0]       Lut_off,
    output logic [PC_W-1:0]         PC,
    output logic                    Running,
    output logic                    Done,
    output logic [CNT_W-1:0]        Cycle_ct
);

    localparam int EXT_W = PC_W + 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [EXT_W-1:0]   off_ext;

    // Widen first so the offset is sign-extended for any PC_W, then keep the low PC_W bits.
    assign off_ext = {{PC_W{Lut_off[7]}}, Lut_off};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_HALT: if (Start)   state_d = S_RUN;
            S_RUN:          if (Halt_in) state_d = S_HALT;
            default:                     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pc_d   = pc_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (Start) begin
                    pc_d  = '0;
                    cnt_d = '0;
                end
            end
            S_RUN: begin
                if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
                done_d = Halt_in;
                if (Halt_in || Stall) begin
                    pc_d = pc_q;
                end else if (Branch_en && (Lut_off != 8'sd0)) begin
                    pc_d = pc_q + off_ext[PC_W-1:0];
                end else begin
                    // A zero offset marks an unmapped LUT entry and falls through.
                    pc_d = pc_q + PC_W'(1);
                end
            end
            default: begin
                pc_d  = '0;
                cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        Lut_ptr  = Target_in;
        PC       = pc_q;
        Running  = (state_q == S_RUN);
        Done     = done_q;
        Cycle_ct = cnt_q;
    end

endmodule

// File: tb/tb_pc_seq.sv
// Bench for pc_seq: directed plan steps, randomized traffic and counter saturation against a behavioural model.
module tb_pc_seq;

    localparam int PC_W   = 8;
    localparam int PTR_W  = 5;
    localparam int CNT_W  = 16;
    localparam int PC_MOD = 1 << PC_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               Clk;
    logic               Reset_n;
    logic               Start;
    logic               Stall;
    logic               Branch_en;
    logic               Halt_in;
    logic [PTR_W-1:0]   Target_in;
    logic [PTR_W-1:0]   Lut_ptr;
    logic signed [7:0]  Lut_off;
    logic [PC_W-1:0]    PC;
    logic               Running;
    logic               Done;
    logic [CNT_W-1:0]   Cycle_ct;

    int n_cmp  = 0;
    int n_fail = 0;

    int m_pc;
    int m_cnt;
    bit m_run;
    bit m_done;

    pc_seq #(.PC_W(PC_W), .PTR_W(PTR_W), .CNT_W(CNT_W)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Start     (Start),
        .Stall     (Stall),
        .Branch_en (Branch_en),
        .Halt_in   (Halt_in),
        .Target_in (Target_in),
        .Lut_ptr   (Lut_ptr),
        .Lut_off   (Lut_off),
        .PC        (PC),
        .Running   (Running),
        .Done      (Done),
        .Cycle_ct  (Cycle_ct)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc   = 0;
        m_cnt  = 0;
        m_run  = 1'b0;
        m_done = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit nd;
        nd = 1'b0;
        if (!m_run) begin
            if (Start) begin
                m_run = 1'b1;
                m_pc  = 0;
                m_cnt = 0;
            end
        end else begin
            m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            if (Halt_in) begin
                m_run = 1'b0;
                nd    = 1'b1;
            end else if (Stall) begin
                m_pc = m_pc;
            end else if (Branch_en && Lut_off != 0) begin
                m_pc = (m_pc + int'(Lut_off) + PC_MOD) % PC_MOD;
            end else begin
                m_pc = (m_pc + 1) % PC_MOD;
            end
        end
        m_done = nd;
    endtask

    task automatic check_all();
        chk("pc",       32'(PC),       32'(m_pc));
        chk("running",  32'(Running),  32'(m_run));
        chk("done",     32'(Done),     32'(m_done));
        chk("cycle_ct", 32'(Cycle_ct), 32'(m_cnt));
    endtask

    task automatic tick();
        model_step();
        @(posedge Clk);
        #1;
        check_all();
    endtask

    task automatic set_in(input bit st, input bit sl, input bit br, input bit hl,
                          input int tgt, input int off);
        Start     = st;
        Stall     = sl;
        Branch_en = br;
        Halt_in   = hl;
        Target_in = PTR_W'(tgt);
        Lut_off   = 8'(off);
    endtask

    // Pull reset low between clock edges and confirm the abort is immediate.
    task automatic async_reset();
        #3;
        Reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge Clk);
        #1;
        check_all();
        Reset_n = 1'b1;
    endtask

    initial begin
        Reset_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
        model_reset();
        #2;
        check_all();
        @(posedge Clk);
        #1;
        check_all();
        Reset_n = 1'b1;

        // Launch, then five sequential cycles.
        set_in(1, 0, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        repeat (5) tick();
        chk("seq_pc5", 32'(PC), 32'd5);
        chk("seq_cnt5", 32'(Cycle_ct), 32'd5);
        repeat (5) tick();

        // Forward and backward branches from PC 10.
        set_in(0, 0, 1, 0, 2, 6);
        #1;
        chk("lut_ptr2", 32'(Lut_ptr), 32'd2);
        tick();
        chk("br_fwd", 32'(PC), 32'd16);
        set_in(0, 0, 1, 0, 1, -11);
        tick();
        chk("br_back", 32'(PC), 32'd5);

        // Wrap below zero, wrap past 255, and an unmapped (zero) offset.
        set_in(0, 0, 1, 0, 3, -2);
        tick();
        set_in(0, 0, 1, 0, 4, -18);
        tick();
        chk("br_wrap", 32'(PC), 32'd241);
        set_in(0, 0, 1, 0, 5, 14);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        tick();
        chk("seq_wrap", 32'(PC), 32'd0);
        repeat (7) tick();
        set_in(0, 0, 1, 0, 9, 0);
        tick();
        chk("br_zero", 32'(PC), 32'd8);

        // Stall with a pending branch, then halt while stalled.
        set_in(0, 0, 1, 0, 6, 12);
        tick();
        set_in(1, 1, 1, 0, 7, 5);
        repeat (3) tick();
        chk("stall_pc", 32'(PC), 32'd20);
        set_in(0, 1, 0, 1, 0, 0);
        tick();
        chk("halt_done", 32'(Done), 32'd1);
        set_in(0, 0, 1, 0, 3, 9);
        repeat (3) tick();
        chk("halt_pc", 32'(PC), 32'd20);

        // Relaunch from HALT, then abort asynchronously mid-run.
        set_in(1, 0, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        repeat (4) tick();
        async_reset();
        chk("rst_running", 32'(Running), 32'd0);
        tick();

        // Randomized traffic including occasional mid-cycle resets.
        for (int i = 0; i < 600; i++) begin
            Start     = ($urandom_range(9) == 0);
            Halt_in   = ($urandom_range(19) == 0);
            Stall     = ($urandom_range(3) == 0);
            Branch_en = ($urandom_range(4) < 2);
            Target_in = PTR_W'($urandom);
            Lut_off   = ($urandom_range(5) == 0) ? 8'sd0 : 8'($urandom);
            #1;
            chk("lut_ptr_rnd", 32'(Lut_ptr), 32'(Target_in));
            tick();
            if ($urandom_range(99) == 0) async_reset();
        end

        // Cycle counter saturation.
        async_reset();
        set_in(1, 0, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        repeat (CNT_MAX + 4) tick();
        chk("cnt_sat", 32'(Cycle_ct), 32'(CNT_MAX));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
